// File: rtl/cus19_mem_access_unit_if.sv
// Request, data-memory and load-result signals of the memory-access stage.
// The slave modport is the unit itself; the master modport is its surroundings
// (IE stage, data memory and load unit seen together).
interface cus19_mem_access_unit_if #(
   parameter int ADDR_W    = 8,
   parameter int REG_IDX_W = 4
);
   logic                 req_valid_in;
   logic                 req_ready_out;
   logic                 req_is_store_in;
   logic [ADDR_W-1:0]    req_addr_in;
   logic [15:0]          req_wr_data_in;
   logic [REG_IDX_W-1:0] req_rd_idx_in;
   logic                 flush_in;

   logic [ADDR_W-1:0]    dm_addr_out;
   logic                 dm_rd_en_out;
   logic                 dm_wr_en_out;
   logic [7:0]           dm_wr_data_out;
   logic [7:0]           dm_rd_data_in;

   logic                 ld_valid_out;
   logic                 ld_ready_in;
   logic [7:0]           ld_data_out;
   logic [REG_IDX_W-1:0] ld_rd_idx_out;
   logic                 ld_reg_wr_out;
   logic                 stall_out;

   modport slave (
      input  req_valid_in, req_is_store_in, req_addr_in, req_wr_data_in,
             req_rd_idx_in, flush_in, dm_rd_data_in, ld_ready_in,
      output req_ready_out, dm_addr_out, dm_rd_en_out, dm_wr_en_out,
             dm_wr_data_out, ld_valid_out, ld_data_out, ld_rd_idx_out,
             ld_reg_wr_out, stall_out
   );

   modport master (
      output req_valid_in, req_is_store_in, req_addr_in, req_wr_data_in,
             req_rd_idx_in, flush_in, dm_rd_data_in, ld_ready_in,
      input  req_ready_out, dm_addr_out, dm_rd_en_out, dm_wr_en_out,
             dm_wr_data_out, ld_valid_out, ld_data_out, ld_rd_idx_out,
             ld_reg_wr_out, stall_out
   );
endinterface

// File: rtl/cus19_mem_access_unit.sv
// Memory-access stage: takes one LD/ST at a time from IE, drives the
// synchronous byte-wide data memory and presents load results to the load unit.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | ready for a request; only state with req_ready_out high
// ST_WR    | one-cycle write strobe with latched address and low byte
// LD_ISSUE | one-cycle read strobe with latched address
// LD_WAIT  | counting out the memory read latency; byte captured on last cycle
// LD_RESP  | load result offered; ld_valid_out rises one cycle after entry
//
// Every strobe and result signal is a flop, so a load result is captured on
// entry to LD_RESP and advertised one cycle later; the handshake only
// completes once ld_valid_out is actually visible.
module cus19_mem_access_unit #(
   parameter int ADDR_W    = 8,
   parameter int RD_LAT    = 1,
   parameter int REG_IDX_W = 4
) (
   input logic                    clk,
   input logic                    rst,
   cus19_mem_access_unit_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ST_WR    = 3'd1,
      LD_ISSUE = 3'd2,
      LD_WAIT  = 3'd3,
      LD_RESP  = 3'd4
   } state_t;

   localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [7:0]           wr_byte_q, wr_byte_d;
   logic [REG_IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic [2:0]           cnt_q, cnt_d;
   logic                 drop_q, drop_d;
   logic [7:0]           ld_data_q, ld_data_d;
   logic                 rd_en_q, rd_en_d;
   logic                 wr_en_q, wr_en_d;
   logic                 ld_valid_q, ld_valid_d;

   // Upper operand bits never reach the byte-wide memory.
   logic unused_wr_hi;
   assign unused_wr_hi = ^bus.req_wr_data_in[15:8];

   // State register and all registered outputs, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wr_byte_q  <= '0;
         rd_idx_q   <= '0;
         cnt_q      <= '0;
         drop_q     <= 1'b0;
         ld_data_q  <= '0;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         ld_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wr_byte_q  <= wr_byte_d;
         rd_idx_q   <= rd_idx_d;
         cnt_q      <= cnt_d;
         drop_q     <= drop_d;
         ld_data_q  <= ld_data_d;
         rd_en_q    <= rd_en_d;
         wr_en_q    <= wr_en_d;
         ld_valid_q <= ld_valid_d;
      end
   end

   // Next-state, request latching, latency count, flush handling and strobes.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wr_byte_d = wr_byte_q;
      rd_idx_d  = rd_idx_q;
      cnt_d     = cnt_q;
      drop_d    = drop_q;
      ld_data_d = ld_data_q;

      unique case (state_q)
         IDLE: begin
            // Flush is irrelevant here: a request in the same cycle still goes.
            if (bus.req_valid_in) begin
               addr_d    = bus.req_addr_in;
               wr_byte_d = bus.req_wr_data_in[7:0];
               rd_idx_d  = bus.req_rd_idx_in;
               state_d   = bus.req_is_store_in ? ST_WR : LD_ISSUE;
            end
         end
         ST_WR: begin
            state_d = IDLE;
         end
         LD_ISSUE: begin
            cnt_d   = LAT_LOAD;
            state_d = LD_WAIT;
            if (bus.flush_in) drop_d = 1'b1;
         end
         LD_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (bus.flush_in) drop_d = 1'b1;
            // The read is always waited out so no late data can surface later.
            if (cnt_q == 3'd1) begin
               ld_data_d = bus.dm_rd_data_in;
               drop_d    = 1'b0;
               state_d   = (drop_q || bus.flush_in) ? IDLE : LD_RESP;
            end
         end
         LD_RESP: begin
            if (bus.flush_in || (ld_valid_q && bus.ld_ready_in)) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      rd_en_d    = (state_d == LD_ISSUE);
      wr_en_d    = (state_d == ST_WR);
      ld_valid_d = (state_q == LD_RESP) && (state_d == LD_RESP);
   end

   assign bus.req_ready_out  = !rst && (state_q == IDLE);
   assign bus.stall_out      = !rst && (state_q != IDLE);
   assign bus.dm_addr_out    = addr_q;
   assign bus.dm_rd_en_out   = rd_en_q;
   assign bus.dm_wr_en_out   = wr_en_q;
   assign bus.dm_wr_data_out = wr_byte_q;
   assign bus.ld_valid_out   = ld_valid_q;
   assign bus.ld_reg_wr_out  = ld_valid_q;
   assign bus.ld_data_out    = ld_data_q;
   assign bus.ld_rd_idx_out  = rd_idx_q;

endmodule
